// File: rtl/sysid_chk_pkg.sv
// Shared types and constants for the system-ID checker master: FSM state
// encoding, slave word offsets and status-vector bit positions.
package sysid_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_ID  = 2'd1,
        RD_TS  = 2'd2,
        REPORT = 2'd3
    } state_e;

    localparam logic [31:0] OFS_ID = 32'd0;
    localparam logic [31:0] OFS_TS = 32'd4;

    localparam int STAT_ID_OK   = 0;
    localparam int STAT_TS_OK   = 1;
    localparam int STAT_TIMEOUT = 2;
    localparam int STAT_W       = 3;

endpackage

// File: rtl/sysid_chk_timer.sv
// Loadable down-counter that parks at zero and flags expiry while at zero.
// Serves the waitrequest timeout and the optional periodic recheck.
module sysid_chk_timer #(
    parameter int           W    = 32,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= INIT;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/sysid_checker_master.sv
// Avalon-MM read master that fetches the system-ID and timestamp words and
// compares them with build-time values. Optional macro: SYSID_PERIODIC_EN.
module sysid_checker_master
    import sysid_chk_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] SYSID_BASE     = '0,
    parameter logic [31:0]       EXPECTED_ID    = 32'h70AB_1BF0,
    parameter logic [31:0]       EXPECTED_TS    = 32'h4F35_D104,
    parameter int                TIMEOUT_CYCLES = 256,
    parameter int                AUTO_START     = 1
`ifdef SYSID_PERIODIC_EN
    ,
    parameter int                RECHECK_CYCLES = 2**24
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    input  logic              master_waitrequest,
    input  logic [31:0]       master_readdata,
    output logic              busy,
    output logic              done,
    output logic              id_ok,
    output logic              ts_ok,
    output logic              timeout,
    output logic [31:0]       id_value,
    output logic [31:0]       ts_value
);

    localparam int CNT_W = 32;

    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_RD_ID  = 2'(RD_ID);
    localparam logic [1:0] ST_RD_TS  = 2'(RD_TS);
    localparam logic [1:0] ST_REPORT = 2'(REPORT);

    logic [1:0]        state;
    logic              boot;
    logic [STAT_W-1:0] status;
    logic              go;
    logic              accept;
    logic              stall;
    logic              abort;
    logic              to_load;
    logic              to_expired;

    function automatic logic [STAT_W-1:0] timeout_status();
        logic [STAT_W-1:0] s;
        s               = '0;
        s[STAT_TIMEOUT] = 1'b1;
        return s;
    endfunction

    assign accept = master_read && !master_waitrequest;
    assign stall  = master_read && master_waitrequest;
    // Only a read that is still stalled when the budget runs out aborts; a
    // grant on the final cycle wins.
    assign abort  = stall && to_expired;

`ifdef SYSID_PERIODIC_EN
    logic rc_expired;

    assign go = (state == ST_IDLE) && (start || boot || rc_expired);

    sysid_chk_timer #(
        .W    (CNT_W),
        .INIT (CNT_W'(RECHECK_CYCLES - 1))
    ) u_recheck (
        .clk        (clk),
        .reset      (reset),
        .load       (go),
        .load_value (CNT_W'(RECHECK_CYCLES - 1)),
        .dec        (state == ST_IDLE),
        .expired    (rc_expired)
    );
`else
    assign go = (state == ST_IDLE) && (start || boot);
`endif

    // Reload at every read assertion: entry to RD_ID and the end of the gap.
    assign to_load = go || ((state == ST_RD_TS) && !master_read);

    sysid_chk_timer #(
        .W (CNT_W)
    ) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .load       (to_load),
        .load_value (CNT_W'(TIMEOUT_CYCLES - 1)),
        .dec        (stall),
        .expired    (to_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            boot           <= (AUTO_START != 0);
            master_read    <= 1'b0;
            master_address <= SYSID_BASE;
            busy           <= 1'b0;
            done           <= 1'b0;
            status         <= '0;
            id_value       <= '0;
            ts_value       <= '0;
        end else begin
            boot <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state          <= ST_RD_ID;
                        busy           <= 1'b1;
                        master_read    <= 1'b1;
                        master_address <= SYSID_BASE + ADDR_W'(OFS_ID);
                        status         <= '0;
                    end
                end
                ST_RD_ID: begin
                    if (accept) begin
                        id_value    <= master_readdata;
                        master_read <= 1'b0;
                        state       <= ST_RD_TS;
                    end else if (abort) begin
                        master_read <= 1'b0;
                        status      <= timeout_status();
                        done        <= 1'b1;
                        state       <= ST_REPORT;
                    end
                end
                ST_RD_TS: begin
                    if (!master_read) begin
                        master_read    <= 1'b1;
                        master_address <= SYSID_BASE + ADDR_W'(OFS_TS);
                    end else if (accept) begin
                        ts_value             <= master_readdata;
                        master_read          <= 1'b0;
                        status[STAT_ID_OK]   <= (id_value == EXPECTED_ID);
                        status[STAT_TS_OK]   <= (master_readdata == EXPECTED_TS);
                        status[STAT_TIMEOUT] <= 1'b0;
                        done                 <= 1'b1;
                        state                <= ST_REPORT;
                    end else if (abort) begin
                        master_read <= 1'b0;
                        status      <= timeout_status();
                        done        <= 1'b1;
                        state       <= ST_REPORT;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign id_ok   = status[STAT_ID_OK];
    assign ts_ok   = status[STAT_TS_OK];
    assign timeout = status[STAT_TIMEOUT];

endmodule
